line_buffer_ctl: RTL and testbench

// Sequencer for the CGIA line_buffers pair. Decides which buffer is displayed and which is filled.

---
 rtl/line_buffer_ctl_if.sv | 44 ++++
 rtl/line_buffer_ctl.sv | 163 ++++++++++++++++
 tb/tb_line_buffer_ctl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_buffer_ctl_if.sv
// Line-buffer sequencer port bundle.
// Groups the scanline strobe, fetch-side controls, the fill handshake with the
// video DMA requester, and the write/read drive into the line_buffers pair.
//   slave  : seen by line_buffer_ctl (takes strobes and fill data, drives buffer controls)
//   master : seen by the environment (DMA requester, timing generator, buffers)
// Signals:
//   LINE_I, DOT_EN_I, CFG_LAST_I[AW], DSCAN_I, UNDERRUN_CLR_I   timing/config in
//   D_STB_I, D_DAT_I[DW] / D_REQ_O, D_ACK_O                     fill handshake
//   ODD_O, F_ADR_O[AW], S_ADR_O[AW], S_DAT_O[DW], S_WE_O        to line_buffers
//   UNDERRUN_O                                                  sticky status
interface line_buffer_ctl_if #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 16
) ();
    logic          LINE_I;
    logic          DOT_EN_I;
    logic [AW-1:0] CFG_LAST_I;
    logic          DSCAN_I;
    logic          D_REQ_O;
    logic          D_STB_I;
    logic [DW-1:0] D_DAT_I;
    logic          D_ACK_O;
    logic          ODD_O;
    logic [AW-1:0] F_ADR_O;
    logic [AW-1:0] S_ADR_O;
    logic [DW-1:0] S_DAT_O;
    logic          S_WE_O;
    logic          UNDERRUN_O;
    logic          UNDERRUN_CLR_I;

    modport slave (
        input  LINE_I, DOT_EN_I, CFG_LAST_I, DSCAN_I,
        input  D_STB_I, D_DAT_I, UNDERRUN_CLR_I,
        output D_REQ_O, D_ACK_O, ODD_O, F_ADR_O,
        output S_ADR_O, S_DAT_O, S_WE_O, UNDERRUN_O
    );

    modport master (
        output LINE_I, DOT_EN_I, CFG_LAST_I, DSCAN_I,
        output D_STB_I, D_DAT_I, UNDERRUN_CLR_I,
        input  D_REQ_O, D_ACK_O, ODD_O, F_ADR_O,
        input  S_ADR_O, S_DAT_O, S_WE_O, UNDERRUN_O
    );
endinterface

// File: rtl/line_buffer_ctl.sv
// line_buffer_ctl: sequencer for the CGIA line_buffers pair.
// Chooses the displayed vs. filled buffer (ODD_O), walks the fetch address on
// the dot enable, and fills the back buffer from a STB/ACK word stream.
// Ports:
//   CLK_I    system clock, rising edge
//   RST_N_I  asynchronous active-low reset
//   bus      line_buffer_ctl_if.slave (see interface header for signal list)
// Build option:
//   LBCTL_DOUBLE_SCAN_EN  when defined, DSCAN_I=1 makes ODD_O flip on every
//                         second LINE_I; otherwise every LINE_I flips.
// Only D_ACK_O, S_WE_O and S_DAT_O are combinational; all other outputs are flops.
module line_buffer_ctl #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 16
) (
    input  logic             CLK_I,
    input  logic             RST_N_I,
    line_buffer_ctl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          odd_q, odd_d;
    logic [AW-1:0] f_adr_q, f_adr_d;
    logic [AW-1:0] s_adr_q, s_adr_d;
    logic [AW-1:0] last_q, last_d;
    logic          req_q, req_d;
    logic          underrun_q, underrun_d;

    logic          flip_c;
    logic          ack_c;
    logic          underrun_set_c;

`ifdef LBCTL_DOUBLE_SCAN_EN
    // Scan phase: only phase-0 lines flip while double scan is selected.
    logic phase_q, phase_d;

    always_comb begin
        phase_d = phase_q;
        if (!bus.DSCAN_I) begin
            phase_d = 1'b0;
        end else if (bus.LINE_I) begin
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign flip_c = bus.LINE_I & (~bus.DSCAN_I | ~phase_q);
`else
    // Single scan: every scanline swaps the buffers; DSCAN_I has no effect.
    logic unused_dscan;
    assign unused_dscan = bus.DSCAN_I;
    assign flip_c       = bus.LINE_I;
`endif

    // A word is taken only while requesting, and never on a scanline strobe.
    assign ack_c = req_q & bus.D_STB_I & ~bus.LINE_I;

    // A flip that lands while the fill is still running is an underrun.
    assign underrun_set_c = flip_c & (state_q == ST_FILL);

    // Next-state, fill counter, fetch counter and status.
    always_comb begin
        state_d    = state_q;
        odd_d      = odd_q;
        f_adr_d    = f_adr_q;
        s_adr_d    = s_adr_q;
        last_d     = last_q;
        underrun_d = underrun_q;

        unique case (state_q)
            ST_IDLE: begin
                if (flip_c) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (flip_c) begin
                    state_d = ST_FILL;
                end else if (ack_c && (s_adr_q == last_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (flip_c) begin
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Buffer swap restarts the fill with the newly sampled line length.
        if (flip_c) begin
            odd_d   = ~odd_q;
            s_adr_d = '0;
            last_d  = bus.CFG_LAST_I;
        end else if (ack_c && (s_adr_q != last_q)) begin
            s_adr_d = AW'(s_adr_q + AW'(1));
        end

        // Fetch address: any LINE_I rewinds, otherwise saturate at last.
        if (bus.LINE_I) begin
            f_adr_d = '0;
        end else if (bus.DOT_EN_I && (f_adr_q < last_q)) begin
            f_adr_d = AW'(f_adr_q + AW'(1));
        end

        // Set has priority over clear.
        if (underrun_set_c) begin
            underrun_d = 1'b1;
        end else if (bus.UNDERRUN_CLR_I) begin
            underrun_d = 1'b0;
        end

        req_d = (state_d == ST_FILL);
    end

    // State register.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_q    <= ST_IDLE;
            odd_q      <= 1'b0;
            f_adr_q    <= '0;
            s_adr_q    <= '0;
            last_q     <= '0;
            req_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            odd_q      <= odd_d;
            f_adr_q    <= f_adr_d;
            s_adr_q    <= s_adr_d;
            last_q     <= last_d;
            req_q      <= req_d;
            underrun_q <= underrun_d;
        end
    end

    // Output drive.
    assign bus.D_REQ_O    = req_q;
    assign bus.D_ACK_O    = ack_c;
    assign bus.S_WE_O     = ack_c;
    assign bus.S_DAT_O    = DW'(bus.D_DAT_I);
    assign bus.S_ADR_O    = s_adr_q;
    assign bus.F_ADR_O    = f_adr_q;
    assign bus.ODD_O      = odd_q;
    assign bus.UNDERRUN_O = underrun_q;

endmodule

// File: tb/tb_line_buffer_ctl.sv
// Self-checking bench for line_buffer_ctl. Writes seen on S_WE_O are checked
// against a queue of expected (address, data, buffer) entries and stored into
// a two-buffer memory model used for display readback checks.
module tb_line_buffer_ctl;
    localparam int unsigned AW = 9;
    localparam int unsigned DW = 16;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic          bsel;   // 0 = even buffer, 1 = odd buffer
    } wr_t;

    wr_t           exp_q[$];
    wr_t           mon_e;
    logic [DW-1:0] mem_even [2**AW];
    logic [DW-1:0] mem_odd  [2**AW];

    int fexp [6] = '{0, 1, 2, 3, 3, 3};
`ifdef LBCTL_DOUBLE_SCAN_EN
    int oexp [4] = '{1, 1, 0, 0};
    int uexp [4] = '{0, 0, 1, 1};
`else
    int oexp [4] = '{1, 0, 1, 0};
    int uexp [4] = '{0, 1, 1, 1};
`endif

    line_buffer_ctl_if #(.AW(AW), .DW(DW)) bus ();

    line_buffer_ctl #(.AW(AW), .DW(DW)) dut (
        .CLK_I   (clk),
        .RST_N_I (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: pops one expected entry per observed write.
    always @(negedge clk) begin
        if (bus.S_WE_O === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got adr=%0h dat=%0h odd=%0b, required no write",
                         bus.S_ADR_O, bus.S_DAT_O, bus.ODD_O);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.S_ADR_O !== mon_e.adr || bus.S_DAT_O !== mon_e.dat ||
                    bus.ODD_O !== ~mon_e.bsel) begin
                    errors++;
                    $display("FAIL write_payload: got adr=%0h dat=%0h odd=%0b, required adr=%0h dat=%0h odd=%0b",
                             bus.S_ADR_O, bus.S_DAT_O, bus.ODD_O, mon_e.adr, mon_e.dat, ~mon_e.bsel);
                end
            end
            if (bus.ODD_O) mem_even[bus.S_ADR_O] = bus.S_DAT_O;
            else           mem_odd[bus.S_ADR_O]  = bus.S_DAT_O;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_wr(input int adr, input int dat, input logic bsel);
        wr_t e;
        e.adr  = AW'(adr);
        e.dat  = DW'(dat);
        e.bsel = bsel;
        exp_q.push_back(e);
    endtask

    // Present n consecutive words (base+i) with STB already high.
    task automatic fill_words(input int base, input int start, input int n, input logic bsel);
        for (int i = 0; i < n; i++) begin
            bus.D_DAT_I = DW'(base + i);
            push_wr(start + i, base + i, bsel);
            step();
        end
    endtask

    task automatic pulse_line();
        bus.LINE_I = 1'b1;
        step();
        bus.LINE_I = 1'b0;
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.LINE_I         = 1'b0;
        bus.DOT_EN_I       = 1'b0;
        bus.CFG_LAST_I     = '0;
        bus.DSCAN_I        = 1'b0;
        bus.D_STB_I        = 1'b0;
        bus.D_DAT_I        = '0;
        bus.UNDERRUN_CLR_I = 1'b0;

        // Reset and idle.
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_odd",      32'(bus.ODD_O), 0);
        check("rst_f_adr",    32'(bus.F_ADR_O), 0);
        check("rst_s_adr",    32'(bus.S_ADR_O), 0);
        check("rst_req",      32'(bus.D_REQ_O), 0);
        check("rst_ack",      32'(bus.D_ACK_O), 0);
        check("rst_we",       32'(bus.S_WE_O), 0);
        check("rst_underrun", 32'(bus.UNDERRUN_O), 0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_req", 32'(bus.D_REQ_O), 0);
        end

        // First line, last=3, streaming fill into the even buffer.
        bus.CFG_LAST_I = AW'(3);
        bus.D_STB_I    = 1'b1;
        bus.D_DAT_I    = DW'(16'hA000);
        pulse_line();
        check("l1_odd",   32'(bus.ODD_O), 1);
        check("l1_req",   32'(bus.D_REQ_O), 1);
        check("l1_s_adr", 32'(bus.S_ADR_O), 0);
        fill_words(32'hA000, 0, 4, 1'b0);
        check("l1_done_req", 32'(bus.D_REQ_O), 0);
        check("l1_done_ack", 32'(bus.D_ACK_O), 0);
        bus.D_STB_I = 1'b0;

        // Second line: display even buffer, fetch saturates at last.
        pulse_line();
        check("l2_odd",      32'(bus.ODD_O), 0);
        check("l2_f_adr",    32'(bus.F_ADR_O), 0);
        check("l2_underrun", 32'(bus.UNDERRUN_O), 0);
        check("l2_req",      32'(bus.D_REQ_O), 1);
        for (int i = 0; i < 6; i++) begin
            check("l2_fetch_adr", 32'(bus.F_ADR_O), 32'(fexp[i]));
            if (i < 4) check("l2_readback", 32'(mem_even[bus.F_ADR_O]), 32'(16'hA000 + i));
            bus.DOT_EN_I = 1'b1;
            step();
        end
        bus.DOT_EN_I = 1'b0;
        bus.D_STB_I  = 1'b1;
        fill_words(32'hB000, 0, 4, 1'b1);
        bus.D_STB_I  = 1'b0;
        check("l2_done_req", 32'(bus.D_REQ_O), 0);

        // Third line, last=7; LINE_I overrides DOT_EN_I; partial fill then underrun.
        bus.CFG_LAST_I = AW'(7);
        bus.DOT_EN_I   = 1'b1;
        pulse_line();
        bus.DOT_EN_I   = 1'b0;
        check("l3_f_adr_override", 32'(bus.F_ADR_O), 0);
        check("l3_odd",            32'(bus.ODD_O), 1);
        check("l3_underrun",       32'(bus.UNDERRUN_O), 0);
        check("l3_readback_odd",   32'(mem_odd[bus.F_ADR_O]), 32'h0000B000);
        bus.D_STB_I = 1'b1;
        fill_words(32'hC000, 0, 2, 1'b0);
        bus.D_STB_I = 1'b0;
        step();
        step();
        check("l3_stall_s_adr", 32'(bus.S_ADR_O), 2);
        check("l3_stall_req",   32'(bus.D_REQ_O), 1);
        pulse_line();
        check("ur_underrun", 32'(bus.UNDERRUN_O), 1);
        check("ur_s_adr",    32'(bus.S_ADR_O), 0);
        check("ur_odd",      32'(bus.ODD_O), 0);
        check("ur_req",      32'(bus.D_REQ_O), 1);
        bus.UNDERRUN_CLR_I = 1'b1;
        step();
        bus.UNDERRUN_CLR_I = 1'b0;
        check("ur_clear", 32'(bus.UNDERRUN_O), 0);
        // Clear and underrun in the same cycle: set wins.
        bus.UNDERRUN_CLR_I = 1'b1;
        pulse_line();
        bus.UNDERRUN_CLR_I = 1'b0;
        check("ur_set_wins", 32'(bus.UNDERRUN_O), 1);
        check("ur_sw_odd",   32'(bus.ODD_O), 1);
        bus.UNDERRUN_CLR_I = 1'b1;
        step();
        bus.UNDERRUN_CLR_I = 1'b0;
        check("ur_clear2", 32'(bus.UNDERRUN_O), 0);

        // LINE_I coincident with STB on a mid-line word.
        bus.D_STB_I = 1'b1;
        fill_words(32'hD000, 0, 3, 1'b0);
        bus.D_DAT_I = DW'(16'hD003);
        bus.LINE_I  = 1'b1;
        @(negedge clk);
        check("mid_ack", 32'(bus.D_ACK_O), 0);
        check("mid_we",  32'(bus.S_WE_O), 0);
        step();
        bus.LINE_I  = 1'b0;
        check("mid_odd",      32'(bus.ODD_O), 0);
        check("mid_s_adr",    32'(bus.S_ADR_O), 0);
        check("mid_underrun", 32'(bus.UNDERRUN_O), 1);
        fill_words(32'hE000, 0, 8, 1'b1);
        bus.D_STB_I = 1'b0;
        check("full_done_req", 32'(bus.D_REQ_O), 0);
        bus.UNDERRUN_CLR_I = 1'b1;
        step();
        bus.UNDERRUN_CLR_I = 1'b0;

        // LINE_I coincident with STB on the last word.
        pulse_line();
        check("lw_underrun0", 32'(bus.UNDERRUN_O), 0);
        check("lw_odd",       32'(bus.ODD_O), 1);
        bus.D_STB_I = 1'b1;
        fill_words(32'hF000, 0, 7, 1'b0);
        bus.D_DAT_I = DW'(16'hF007);
        bus.LINE_I  = 1'b1;
        @(negedge clk);
        check("lw_we", 32'(bus.S_WE_O), 0);
        step();
        bus.LINE_I  = 1'b0;
        bus.D_STB_I = 1'b0;
        check("lw_underrun", 32'(bus.UNDERRUN_O), 1);
        check("lw_odd2",     32'(bus.ODD_O), 0);
        check("lw_s_adr",    32'(bus.S_ADR_O), 0);
        bus.UNDERRUN_CLR_I = 1'b1;
        step();
        bus.UNDERRUN_CLR_I = 1'b0;

        // Reset in the middle of a fill.
        bus.D_STB_I = 1'b1;
        fill_words(32'h5000, 0, 2, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rr_we",    32'(bus.S_WE_O), 0);
        check("rr_req",   32'(bus.D_REQ_O), 0);
        check("rr_odd",   32'(bus.ODD_O), 0);
        check("rr_s_adr", 32'(bus.S_ADR_O), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        step();
        check("rr_idle_req", 32'(bus.D_REQ_O), 0);
        bus.D_STB_I = 1'b0;

        // Scan-mode sequence with DSCAN_I=1 (flip pattern depends on build).
        bus.DSCAN_I    = 1'b1;
        bus.CFG_LAST_I = AW'(7);
        for (int k = 0; k < 4; k++) begin
            bus.DOT_EN_I = 1'b1;
            step();
            step();
            bus.DOT_EN_I = 1'b0;
            if (k > 0) check("ds_f_adr_pre", 32'(bus.F_ADR_O), 2);
            pulse_line();
            check("ds_odd",      32'(bus.ODD_O), 32'(oexp[k]));
            check("ds_f_adr",    32'(bus.F_ADR_O), 0);
            check("ds_underrun", 32'(bus.UNDERRUN_O), 32'(uexp[k]));
        end
`ifdef LBCTL_DOUBLE_SCAN_EN
        bus.DSCAN_I = 1'b0;
        pulse_line();
        check("ds_off_odd", 32'(bus.ODD_O), 1);
        pulse_line();
        check("ds_off_odd2", 32'(bus.ODD_O), 0);
`endif
        bus.DSCAN_I = 1'b0;
        step();

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
